// File: rtl/tqvp_vga_copper_pkg.sv
// Shared definitions for the VGA copper: register map, FSM encoding and list entry layout.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package tqvp_vga_copper_pkg;

  localparam int MAX_ENTRIES = 8;
  localparam int IDX_W       = $clog2(MAX_ENTRIES);      // entry index width
  localparam int PTR_W       = $clog2(MAX_ENTRIES + 1);  // ptr/length can reach MAX_ENTRIES

  // Copper register offsets (byte addresses on the 6-bit peripheral bus)
  localparam logic [5:0] ENTRY_BASE  = 6'h00;
  localparam logic [5:0] CTRL_ADDR   = 6'h20;
  localparam logic [5:0] STATUS_ADDR = 6'h24;

  // Entry word field positions
  localparam int ENT_Y_MSB    = 31;
  localparam int ENT_Y_LSB    = 22;
  localparam int ENT_ADDR_MSB = 21;
  localparam int ENT_ADDR_LSB = 16;
  localparam int ENT_DATA_MSB = 8;
  localparam int ENT_DATA_LSB = 0;

  // CTRL / STATUS field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_LEN_MSB  = 7;
  localparam int CTRL_LEN_LSB  = 4;
  localparam int STAT_PTR_MSB  = 2;
  localparam int STAT_PTR_LSB  = 0;
  localparam int STAT_ST_MSB   = 4;
  localparam int STAT_ST_LSB   = 3;
  localparam int STAT_STALL    = 5;

  // TinyQV transfer-size encoding on data_write_n / data_read_n
  localparam logic [1:0] XFER_IDLE = 2'b11;
  localparam logic [1:0] XFER_32   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_ISSUE = 2'd2
  } cop_state_t;

  typedef struct packed {
    logic [ENT_Y_MSB-ENT_Y_LSB:0]       y;
    logic [ENT_ADDR_MSB-ENT_ADDR_LSB:0] addr;
    logic [ENT_DATA_MSB-ENT_DATA_LSB:0] data;
  } entry_t;

  // Rebuild the CPU-visible entry word; reserved bits read as zero.
  function automatic logic [31:0] pack_entry(input entry_t e);
    logic [31:0] w;
    w = '0;
    w[ENT_Y_MSB:ENT_Y_LSB]       = e.y;
    w[ENT_ADDR_MSB:ENT_ADDR_LSB] = e.addr;
    w[ENT_DATA_MSB:ENT_DATA_LSB] = e.data;
    return w;
  endfunction

  // Lengths above the list size behave as a full list.
  function automatic logic [PTR_W-1:0] clamp_len(input logic [3:0] l);
    return (l > 4'(MAX_ENTRIES)) ? PTR_W'(MAX_ENTRIES) : PTR_W'(l);
  endfunction

endpackage

// File: rtl/tqvp_vga_copper_if.sv
// TinyQV peripheral bus bundle: address/data/strobes one way, read data and ready the other.
// Latency: n/a (wires only).
// Backpressure: data_ready qualifies read data; writes are fire-and-forget.
// Ports: master drives address, data_in, data_write_n, data_read_n and samples
// data_out, data_ready; slave is the mirror image.
interface tqvp_vga_copper_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/vga_copper_arb.sv
// CPU/copper mux for the VGA register port: fixed CPU priority, copper gets leftover cycles.
// Latency: purely combinational, zero cycles.
// Backpressure: a CPU pass-through access withholds cop_grant; the copper must hold its request.
// Ports: cop_sel, cpu (slave side of CPU bus), vga (master side of VGA bus),
// cop_req/cop_addr/cop_wdata from the copper FSM, reg_rdata for copper register reads,
// cop_grant and cpu_pt_active back to the FSM.
module vga_copper_arb
  import tqvp_vga_copper_pkg::*;
(
  input  logic                     cop_sel,
  tqvp_vga_copper_if.slave         cpu,
  tqvp_vga_copper_if.master        vga,
  input  logic                     cop_req,
  input  logic [5:0]               cop_addr,
  input  logic [31:0]              cop_wdata,
  input  logic [31:0]              reg_rdata,
  output logic                     cop_grant,
  output logic                     cpu_pt_active
);

  assign cpu_pt_active = !cop_sel &&
                         ((cpu.data_write_n != XFER_IDLE) || (cpu.data_read_n != XFER_IDLE));

  // The copper only owns the port in cycles the CPU leaves unused, so the two
  // can never drive the VGA strobes together.
  assign cop_grant = cop_req && !cpu_pt_active;

  assign vga.address      = cop_grant ? cop_addr  : cpu.address;
  assign vga.data_in      = cop_grant ? cop_wdata : cpu.data_in;
  assign vga.data_write_n = cop_grant ? XFER_32   :
                            (cop_sel  ? XFER_IDLE : cpu.data_write_n);
  assign vga.data_read_n  = (cop_grant || cop_sel) ? XFER_IDLE : cpu.data_read_n;

  // Copper registers answer in the same cycle, so ready is constant when selected.
  assign cpu.data_out   = cop_sel ? reg_rdata : vga.data_out;
  assign cpu.data_ready = cop_sel ? 1'b1      : vga.data_ready;

endmodule

// File: rtl/tqvp_vga_copper.sv
// VGA copper: replays a list of (y, reg, data) writes into the VGA peripheral as scanlines start.
// Latency: first write of a matching line 2 cycles after the scanline pulse, then one per 2 cycles.
// Backpressure: CPU pass-through accesses stall a pending copper write (held, stall-seen set).
// Ports: clk, rst_n (sync, active-low), cop_sel, cpu (CPU bus, slave), vga (VGA bus, master),
// vga_y / vga_new_scanline from the video timing, cop_busy while the sequencer is active.
module tqvp_vga_copper
  import tqvp_vga_copper_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cop_sel,
  tqvp_vga_copper_if.slave  cpu,
  tqvp_vga_copper_if.master vga,
  input  logic [9:0]        vga_y,
  input  logic              vga_new_scanline,
  output logic              cop_busy
);

  entry_t            entries [MAX_ENTRIES];
  cop_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  length;
  logic [9:0]        cur_y;
  logic              enable;
  logic              stall_seen;

  logic              reg_wr;
  logic              entry_wr;
  logic              ctrl_wr;
  logic              ctrl_disable;
  logic              ptr_in_range;
  entry_t            cur_entry;
  logic              cop_req;
  logic              cop_grant;
  logic              cpu_pt_active;
  logic [31:0]       reg_rdata;
  logic              unused_rsvd;

  // Only full-word writes reach copper registers; byte/half writes are dropped.
  assign reg_wr       = cop_sel && (cpu.data_write_n == XFER_32);
  assign entry_wr     = reg_wr && (cpu.address < CTRL_ADDR);
  assign ctrl_wr      = reg_wr && (cpu.address == CTRL_ADDR);
  assign ctrl_disable = ctrl_wr && !cpu.data_in[CTRL_EN_BIT];

  assign ptr_in_range = (ptr < length);
  assign cur_entry    = entries[ptr[IDX_W-1:0]];

  // Request is squashed by reset and by a disabling CTRL write in the same
  // cycle, so an abandoned issue never reaches the VGA port.
  assign cop_req  = rst_n && (state == ST_ISSUE) && !ctrl_disable;
  assign cop_busy = (state != ST_IDLE);

  assign unused_rsvd = ^cpu.data_in[15:9];

  vga_copper_arb u_arb (
    .cop_sel       (cop_sel),
    .cpu           (cpu),
    .vga           (vga),
    .cop_req       (cop_req),
    .cop_addr      (cur_entry.addr),
    .cop_wdata     ({23'b0, cur_entry.data}),
    .reg_rdata     (reg_rdata),
    .cop_grant     (cop_grant),
    .cpu_pt_active (cpu_pt_active)
  );

  // List storage: deliberately not reset, software must load it before enabling.
  always_ff @(posedge clk) begin
    if (entry_wr) begin
      entries[cpu.address[IDX_W+1:2]] <= '{
        y:    cpu.data_in[ENT_Y_MSB:ENT_Y_LSB],
        addr: cpu.data_in[ENT_ADDR_MSB:ENT_ADDR_LSB],
        data: cpu.data_in[ENT_DATA_MSB:ENT_DATA_LSB]
      };
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      length     <= '0;
      cur_y      <= '0;
      enable     <= 1'b0;
      stall_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Pulses are only accepted here; while busy the old line keeps running.
          if (vga_new_scanline && enable) begin
            state <= ST_MATCH;
            cur_y <= vga_y;
            if (vga_y == '0) ptr <= '0;
          end
        end
        ST_MATCH: begin
          // First non-matching entry ends the line; unsorted lists just stop early.
          state <= (ptr_in_range && (cur_entry.y == cur_y)) ? ST_ISSUE : ST_IDLE;
        end
        ST_ISSUE: begin
          if (cop_grant) begin
            if (ptr_in_range) ptr <= ptr + PTR_W'(1);
            state <= ST_MATCH;
          end else if (cpu_pt_active) begin
            stall_seen <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (ctrl_wr) begin
        enable     <= cpu.data_in[CTRL_EN_BIT];
        length     <= clamp_len(cpu.data_in[CTRL_LEN_MSB:CTRL_LEN_LSB]);
        stall_seen <= 1'b0;
        // Disabling abandons any in-flight line but keeps ptr where it was.
        if (!cpu.data_in[CTRL_EN_BIT]) state <= ST_IDLE;
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (cpu.address < CTRL_ADDR) begin
      reg_rdata = pack_entry(entries[cpu.address[IDX_W+1:2]]);
    end else if (cpu.address == CTRL_ADDR) begin
      reg_rdata[CTRL_EN_BIT]                = enable;
      reg_rdata[CTRL_LEN_MSB:CTRL_LEN_LSB]  = length;
    end else if (cpu.address == STATUS_ADDR) begin
      reg_rdata[STAT_PTR_MSB:STAT_PTR_LSB]  = ptr[IDX_W-1:0];
      reg_rdata[STAT_ST_MSB:STAT_ST_LSB]    = state;
      reg_rdata[STAT_STALL]                 = stall_seen;
    end
  end

endmodule

// File: tb/tb_tqvp_vga_copper.sv
// Bench for tqvp_vga_copper: scheduled-write model checked every cycle plus literal checks.
module tb_tqvp_vga_copper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cop_sel = 1'b0;
  logic [9:0] vga_y = '0;
  logic       vga_new_scanline = 1'b0;
  logic       cop_busy;

  tqvp_vga_copper_if cpu_if ();
  tqvp_vga_copper_if vga_if ();

  always #5 clk = ~clk;

  tqvp_vga_copper dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cop_sel          (cop_sel),
    .cpu              (cpu_if),
    .vga              (vga_if),
    .vga_y            (vga_y),
    .vga_new_scanline (vga_new_scanline),
    .cop_busy         (cop_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%08h want=0x%08h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A line that matches k entries produces writes at pulse+2, +4, ...;
  // a CPU pass-through on a due cycle simply defers the pending write.
  int m_y[8], m_addr[8], m_data[8];
  bit m_en, m_stall;
  int m_len, m_ptr;
  int pend_a[$], pend_d[$];
  int m_next = 0, m_pulse = -10, m_busy_end = -10;
  localparam int BIG = 1 << 30;

  int log_cyc[$], log_addr[$], log_data[$];

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int model_read(input int a, input bit busy, input bit due);
    int st;
    if (a < 32) return (m_y[a/4] << 22) | (m_addr[a/4] << 16) | m_data[a/4];
    if (a == 32) return (m_len << 4) | int'(m_en);
    if (a == 36) begin
      st = !busy ? 0 : (due ? 2 : 1);
      return (m_ptr % 8) | (st << 3) | (int'(m_stall) << 5);
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    bit pt, ctrl_dis, busy_now, due, exp_cop;
    int a, d, idx;
    logic [1:0] wn, rn;
    wn = cpu_if.data_write_n;
    rn = cpu_if.data_read_n;
    a  = int'(cpu_if.address);
    d  = int'(cpu_if.data_in);
    pt = !cop_sel && (wn != 2'b11 || rn != 2'b11);
    ctrl_dis = rst_n && cop_sel && wn == 2'b10 && a == 32 && !cpu_if.data_in[0];
    busy_now = (cyc > m_pulse) && (cyc <= m_busy_end);
    due = busy_now && pend_a.size() > 0 && cyc >= m_next;
    exp_cop = rst_n && due && !pt && !ctrl_dis;

    if (vga_if.data_write_n == 2'b10) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(int'(vga_if.address));
      log_data.push_back(int'(vga_if.data_in));
    end

    if (exp_cop) begin
      chk("cop_wr_n", 32'(vga_if.data_write_n), 32'd2);
      chk("cop_rd_n", 32'(vga_if.data_read_n), 32'd3);
      chk("cop_addr", 32'(vga_if.address), pend_a[0]);
      chk("cop_data", vga_if.data_in, pend_d[0]);
    end else begin
      chk("vga_wr_n", 32'(vga_if.data_write_n), cop_sel ? 32'd3 : 32'(wn));
      chk("vga_rd_n", 32'(vga_if.data_read_n), cop_sel ? 32'd3 : 32'(rn));
      if (!cop_sel) begin
        chk("pt_addr", 32'(vga_if.address), a);
        chk("pt_data", vga_if.data_in, d);
      end
    end

    if (!cop_sel) begin
      chk("mirror_dout", cpu_if.data_out, vga_if.data_out);
      chk("mirror_rdy", 32'(cpu_if.data_ready), 32'(vga_if.data_ready));
    end else if (rst_n && rn != 2'b11) begin
      chk("reg_rdy", 32'(cpu_if.data_ready), 32'd1);
      chk("reg_rdata", cpu_if.data_out, model_read(a, busy_now, due));
    end

    if (rst_n) chk("busy", 32'(cop_busy), 32'(busy_now));

    if (!rst_n) begin
      m_en = 0; m_len = 0; m_ptr = 0; m_stall = 0;
      pend_a.delete(); pend_d.delete();
      m_pulse = -10; m_busy_end = -10;
    end else begin
      if (exp_cop) begin
        void'(pend_a.pop_front()); void'(pend_d.pop_front());
        m_ptr++;
        m_next = cyc + 2;
        if (pend_a.size() == 0) m_busy_end = cyc + 1;
      end else if (due && pt) begin
        m_stall = 1;
      end
      if (ctrl_dis && busy_now) begin
        pend_a.delete(); pend_d.delete();
        m_busy_end = cyc;
      end
      if (vga_new_scanline && m_en && !busy_now) begin
        if (vga_y == 0) m_ptr = 0;
        idx = m_ptr;
        while (idx < m_len && m_y[idx] == int'(vga_y)) begin
          pend_a.push_back(m_addr[idx]);
          pend_d.push_back(m_data[idx]);
          idx++;
        end
        m_pulse = cyc;
        m_next = cyc + 2;
        m_busy_end = (pend_a.size() > 0) ? BIG : cyc + 1;
      end
      if (cop_sel && wn == 2'b10) begin
        if (a < 32) begin
          m_y[a/4] = (d >> 22) & 'h3FF;
          m_addr[a/4] = (d >> 16) & 'h3F;
          m_data[a/4] = d & 'h1FF;
        end else if (a == 32) begin
          m_en = d[0];
          m_len = ((d >> 4) & 'hF) > 8 ? 8 : ((d >> 4) & 'hF);
          m_stall = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cop_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    cop_sel = 1'b1; cpu_if.address = a; cpu_if.data_in = d; cpu_if.data_write_n = wn;
    tick();
    cop_sel = 1'b0; cpu_if.data_write_n = 2'b11;
  endtask

  task automatic check_reg(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cop_sel = 1'b1; cpu_if.address = a; cpu_if.data_read_n = 2'b10;
    @(negedge clk); v = cpu_if.data_out;
    tick();
    cop_sel = 1'b0; cpu_if.data_read_n = 2'b11;
    chk(name, v, exp);
  endtask

  task automatic pulse(input int y);
    vga_new_scanline = 1'b1; vga_y = 10'(y);
    tick();
    vga_new_scanline = 1'b0;
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_addr.delete(); log_data.delete();
  endtask

  function automatic logic [31:0] mk(input int y, input int a, input int d);
    return (32'(y) << 22) | (32'(a) << 16) | 32'(d);
  endfunction

  int t;
  logic [31:0] v;

  initial begin
    cpu_if.address = '0; cpu_if.data_in = '0;
    cpu_if.data_write_n = 2'b11; cpu_if.data_read_n = 2'b11;
    vga_if.data_out = 32'hCAFE0000; vga_if.data_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    chk("rst_busy", 32'(cop_busy), 32'd0);
    check_reg("rst_status", 6'h24, 32'h0);
    check_reg("rst_ctrl", 6'h20, 32'h0);

    // Single entry, scan y=0..6: only y=5 fires, 2 cycles after its pulse
    cop_write(6'h00, mk(5, 'h30, 3), 2'b10);
    cop_write(6'h20, 32'h11, 2'b10);
    check_reg("entry0_rb", 6'h00, 32'h01700003);
    clear_log();
    for (int y = 0; y <= 6; y++) begin
      if (y == 5) t = cyc;
      pulse(y);
      idle(4);
    end
    chk("t1_count", log_cyc.size(), 1);
    chk("t1_lat", q_at(log_cyc, 0) - t, 2);
    chk("t1_addr", q_at(log_addr, 0), 'h30);
    chk("t1_data", q_at(log_data, 0), 3);

    // Two entries on the same line, then ptr saturates at length
    cop_write(6'h00, mk(10, 'h30, 'h1AB), 2'b10);
    cop_write(6'h04, mk(10, 'h31, 'h055), 2'b10);
    cop_write(6'h20, 32'h21, 2'b10);
    pulse(0); idle(4);
    clear_log();
    t = cyc;
    pulse(10); idle(8);
    chk("t2_count", log_cyc.size(), 2);
    chk("t2_lat", q_at(log_cyc, 0) - t, 2);
    chk("t2_gap", q_at(log_cyc, 1) - q_at(log_cyc, 0), 2);
    chk("t2_data0", q_at(log_data, 0), 'h1AB);
    chk("t2_addr1", q_at(log_addr, 1), 'h31);
    chk("t2_data1", q_at(log_data, 1), 'h55);
    check_reg("t2_status", 6'h24, 32'h02);
    pulse(11); idle(4);
    check_reg("t2_sat", 6'h24, 32'h02);

    // Frame wrap reloads ptr and the line fires again
    pulse(0); idle(4);
    check_reg("t3_ptr0", 6'h24, 32'h00);
    clear_log();
    pulse(10); idle(8);
    chk("t3_count", log_cyc.size(), 2);

    // CPU pass-through write held 3 cycles over the first ISSUE
    pulse(0); idle(4);
    clear_log();
    t = cyc;
    pulse(10); idle(1);
    cpu_if.address = 6'h05; cpu_if.data_in = 32'hDEADBEEF; cpu_if.data_write_n = 2'b10;
    idle(3);
    cpu_if.data_write_n = 2'b11;
    idle(8);
    chk("t4_count", log_cyc.size(), 5);
    chk("t4_cpu_first", q_at(log_addr, 0), 5);
    chk("t4_cpu_cyc", q_at(log_cyc, 0) - t, 2);
    chk("t4_cop_addr", q_at(log_addr, 3), 'h30);
    chk("t4_cop_cyc", q_at(log_cyc, 3) - t, 5);
    chk("t4_cop2_cyc", q_at(log_cyc, 4) - t, 7);
    check_reg("t4_status", 6'h24, 32'h22);
    vga_if.data_out = 32'h12345678; vga_if.data_ready = 1'b1;
    cpu_if.address = 6'h03; cpu_if.data_read_n = 2'b10;
    @(negedge clk); v = cpu_if.data_out;
    tick();
    cpu_if.data_read_n = 2'b11; vga_if.data_ready = 1'b0;
    chk("t4_pt_read", v, 32'h12345678);

    // Narrow writes ignored; disabling during the second ISSUE abandons it
    cop_write(6'h00, 32'hFFFFFFFF, 2'b01);
    cop_write(6'h00, 32'h00000000, 2'b00);
    check_reg("t5_entry0", 6'h00, 32'h02B001AB);
    cop_write(6'h20, 32'h21, 2'b10);
    check_reg("t5_stall_clr", 6'h24, 32'h02);
    pulse(0); idle(4);
    clear_log();
    pulse(10); idle(3);
    cop_write(6'h20, 32'h20, 2'b10);
    @(negedge clk); chk("t5_idle_next", 32'(cop_busy), 32'd0);
    tick();
    idle(4);
    chk("t5_count", log_cyc.size(), 1);
    check_reg("t5_status", 6'h24, 32'h01);
    check_reg("t5_ctrl", 6'h20, 32'h20);

    // Reset asserted on the ISSUE cycle suppresses the write
    cop_write(6'h20, 32'h21, 2'b10);
    pulse(0); idle(4);
    clear_log();
    pulse(10); idle(1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(6);
    chk("t6_count", log_cyc.size(), 0);
    check_reg("t6_status", 6'h24, 32'h0);
    check_reg("t6_ctrl", 6'h20, 32'h0);
    cop_write(6'h20, 32'hF1, 2'b10);
    check_reg("t6_clamp", 6'h20, 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
